// File: rtl/gal_array_if.sv
//------------------------------------------------------------------------------
// gal_array_if : configuration handshake and logic I/O bundle for gal_array
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface gal_array_if #(
  parameter int N = 4,
  parameter int M = 2
);
  logic         cfg_start;
  logic         cfg_valid;
  logic         cfg_data;
  logic         cfg_ready;
  logic         cfg_done;
  logic         cfg_rb;
  logic [N-1:0] input_vars;
  logic [M-1:0] output_vals;

  modport master (
    output cfg_start, cfg_valid, cfg_data, input_vars,
    input  cfg_ready, cfg_done, cfg_rb, output_vals
  );

  modport slave (
    input  cfg_start, cfg_valid, cfg_data, input_vars,
    output cfg_ready, cfg_done, cfg_rb, output_vals
  );
endinterface

`default_nettype wire

// File: rtl/gal_array.sv
//------------------------------------------------------------------------------
// gal_array : serially configured AND/OR array with per-output macrocells
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module gal_array #(
  parameter int N = 4,
  parameter int M = 2,
  parameter int P = 4
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  gal_array_if.slave  bus
);

  localparam int CFG_LEN   = 2*N*P + P*M + 2*M;
  localparam int CW        = $clog2(CFG_LEN + 1);
  localparam int OR_BASE   = 2*N*P;
  localparam int CELL_BASE = 2*N*P + P*M;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  logic [1:0]         state;
  logic [1:0]         state_nxt;
  logic [CFG_LEN-1:0] chain;
  logic [CW-1:0]      bit_cnt;
  logic               accept;
  logic               last_bit;
  logic [2*N-1:0]     lits;
  logic [P-1:0]       prod;
  logic [M-1:0]       sum;
  logic [M-1:0]       f;
  logic [M-1:0]       q;
  logic [M-1:0]       reg_sel;
  logic [M-1:0]       pol;

  // a start pulse wins over a coincident valid bit
  assign accept   = bus.cfg_valid & bus.cfg_ready & ~bus.cfg_start;
  assign last_bit = (bit_cnt == CW'(CFG_LEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.cfg_start) state_nxt = S_LOAD;
      S_LOAD:  if (bus.cfg_start)         state_nxt = S_LOAD;
               else if (accept && last_bit) state_nxt = S_RUN;
      S_RUN:   if (bus.cfg_start) state_nxt = S_LOAD;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.cfg_ready   = (state == S_LOAD);
    bus.cfg_done    = (state == S_RUN);
    bus.output_vals = (state == S_RUN) ? ((reg_sel & q) | (~reg_sel & f)) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             bit_cnt <= '0;
    else if (bus.cfg_start) bit_cnt <= '0;
    else if (accept)        bit_cnt <= last_bit ? '0 : bit_cnt + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      chain <= '0;
    else if (accept) chain <= {chain[CFG_LEN-2:0], bus.cfg_data};
  end

  assign bus.cfg_rb = chain[CFG_LEN-1];

  // empty product term evaluates to 1, empty sum to 0
  always_comb begin
    for (int n = 0; n < N; n++) begin
      lits[2*n]   = bus.input_vars[n];
      lits[2*n+1] = ~bus.input_vars[n];
    end
    for (int p = 0; p < P; p++) begin
      prod[p] = 1'b1;
      for (int k = 0; k < 2*N; k++) begin
        if (chain[p + k*P] && !lits[k]) prod[p] = 1'b0;
      end
    end
    for (int m = 0; m < M; m++) begin
      sum[m] = 1'b0;
      for (int p = 0; p < P; p++) begin
        sum[m] = sum[m] | (chain[OR_BASE + p + m*P] & prod[p]);
      end
    end
  end

  generate
    for (genvar m = 0; m < M; m++) begin : g_cell
      assign reg_sel[m] = chain[CELL_BASE + 2*m];
      assign pol[m]     = chain[CELL_BASE + 2*m + 1];
      assign f[m]       = sum[m] ^ pol[m];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              q[m] <= 1'b0;
        else if (state == S_RUN) q[m] <= f[m];
        else                     q[m] <= 1'b0;
      end
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_gal_array.sv
//------------------------------------------------------------------------------
// tb_gal_array : directed stimulus checked against a behavioural array model
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_gal_array;

  localparam int N         = 4;
  localparam int M         = 2;
  localparam int P         = 4;
  localparam int CFG_LEN   = 2*N*P + P*M + 2*M;
  localparam int OR_BASE   = 2*N*P;
  localparam int CELL_BASE = 2*N*P + P*M;

  localparam logic [CFG_LEN-1:0] CFG_COMB =
    (44'd1 << 0) | (44'd1 << 12) | (44'd1 << 32);
  localparam logic [CFG_LEN-1:0] CFG_REG  =
    (44'd1 << 0) | (44'd1 << 12) | (44'd1 << 36) | (44'd1 << 42) | (44'd1 << 43);

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  gal_array_if #(.N(N), .M(M)) bus ();

  gal_array #(.N(N), .M(M), .P(P)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef enum int {MD_IDLE, MD_LOAD, MD_RUN} mode_t;
  mode_t md;
  int    acc_cnt;
  bit    stream[$];
  bit    mq[M];

  // chain position i holds the i-th most recent accepted bit
  function automatic bit cbit(int i);
    if (i < stream.size()) return stream[stream.size() - 1 - i];
    return 1'b0;
  endfunction

  function automatic bit fval(int m, logic [N-1:0] v);
    bit pr [P];
    bit s = 1'b0;
    for (int p = 0; p < P; p++) begin
      pr[p] = 1'b1;
      for (int k = 0; k < 2*N; k++) begin
        if (cbit(p + k*P)) pr[p] = pr[p] & ((k % 2) ? ~v[k/2] : v[k/2]);
      end
    end
    for (int p = 0; p < P; p++) if (cbit(OR_BASE + p + m*P)) s = s | pr[p];
    return s ^ cbit(CELL_BASE + 2*m + 1);
  endfunction

  function automatic logic [M-1:0] exp_out();
    logic [M-1:0] r = '0;
    if (md == MD_RUN)
      for (int m = 0; m < M; m++)
        r[m] = cbit(CELL_BASE + 2*m) ? mq[m] : fval(m, bus.input_vars);
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md      = MD_IDLE;
      acc_cnt = 0;
      stream.delete();
      for (int m = 0; m < M; m++) mq[m] = 1'b0;
    end else begin
      for (int m = 0; m < M; m++) mq[m] = (md == MD_RUN) ? fval(m, bus.input_vars) : 1'b0;
      case (md)
        MD_IDLE: if (bus.cfg_start) begin md = MD_LOAD; acc_cnt = 0; end
        MD_LOAD: begin
          if (bus.cfg_start) acc_cnt = 0;
          else if (bus.cfg_valid) begin
            stream.push_back(bus.cfg_data);
            if (stream.size() > CFG_LEN) void'(stream.pop_front());
            acc_cnt++;
            if (acc_cnt == CFG_LEN) begin md = MD_RUN; acc_cnt = 0; end
          end
        end
        default: if (bus.cfg_start) md = MD_LOAD;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("ready", 32'(bus.cfg_ready), 32'(md == MD_LOAD));
    check("done",  32'(bus.cfg_done),  32'(md == MD_RUN));
    check("rb",    32'(bus.cfg_rb),    32'(cbit(CFG_LEN - 1)));
    check("out",   32'(bus.output_vals), 32'(exp_out()));
  end

  task automatic cyc(input bit s, input bit v, input bit d);
    bus.cfg_start = s;
    bus.cfg_valid = v;
    bus.cfg_data  = d;
    @(posedge clk);
    #2;
  endtask

  // first bit sent ends up at the chain MSB
  task automatic load(input logic [CFG_LEN-1:0] cfg, input bit with_start, input bit gaps);
    if (with_start) cyc(1'b1, 1'b0, 1'b0);
    for (int i = CFG_LEN - 1; i >= 0; i--) begin
      if (gaps) while ($urandom_range(0, 2) == 0) cyc(1'b0, 1'b0, 1'($urandom));
      if (i == 0) check("done_before_last", 32'(bus.cfg_done), 32'd0);
      cyc(1'b0, 1'b1, cfg[i]);
    end
    bus.cfg_valid = 1'b0;
    check("done_after_last", 32'(bus.cfg_done), 32'd1);
  endtask

  logic [CFG_LEN-1:0] rs;

  initial begin
    rst_n          = 1'b0;
    bus.cfg_start  = 1'b0;
    bus.cfg_valid  = 1'b0;
    bus.cfg_data   = 1'b0;
    bus.input_vars = N'($urandom);
    #1;
    check("rst_out",   32'(bus.output_vals), 32'd0);
    check("rst_ready", 32'(bus.cfg_ready),   32'd0);
    check("rst_done",  32'(bus.cfg_done),    32'd0);
    check("rst_rb",    32'(bus.cfg_rb),      32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n          = 1'b1;
    bus.input_vars = '0;
    cyc(1'b0, 1'b0, 1'b0);

    load(CFG_COMB, 1'b1, 1'b0);
    bus.input_vars = 4'b0001;
    @(negedge clk);
    check("comb_0001", 32'(bus.output_vals[0]), 32'd1);
    @(posedge clk); #2;
    bus.input_vars = 4'b0011;
    @(negedge clk);
    check("comb_0011", 32'(bus.output_vals[0]), 32'd0);
    @(posedge clk); #2;

    bus.input_vars = 4'b0000;
    load(CFG_REG, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    check("reg_high", 32'(bus.output_vals[1]), 32'd1);
    bus.input_vars = 4'b0001;
    @(negedge clk);
    check("reg_hold", 32'(bus.output_vals[1]), 32'd1);
    @(posedge clk); #1;
    check("reg_fall", 32'(bus.output_vals[1]), 32'd0);
    #1;

    rs = {12'($urandom), 32'($urandom)};
    load(rs, 1'b1, 1'b1);
    check("gap_rb", 32'(bus.cfg_rb), 32'(rs[CFG_LEN-1]));

    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 1'($urandom));
    #1;
    rst_n          = 1'b0;
    bus.input_vars = N'($urandom);
    #1;
    check("midload_ready", 32'(bus.cfg_ready),   32'd0);
    check("midload_rb",    32'(bus.cfg_rb),      32'd0);
    check("midload_out",   32'(bus.output_vals), 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    load(CFG_COMB, 1'b1, 1'b1);
    bus.input_vars = 4'b0001;
    @(negedge clk);
    check("after_rst_comb", 32'(bus.output_vals[0]), 32'd1);
    #1;
    rst_n          = 1'b0;
    bus.input_vars = N'($urandom);
    #1;
    check("async_rst_out",  32'(bus.output_vals), 32'd0);
    check("async_rst_done", 32'(bus.cfg_done),    32'd0);
    @(posedge clk); #2;
    rst_n          = 1'b1;
    bus.input_vars = 4'b0000;
    cyc(1'b0, 1'b0, 1'b0);

    load(CFG_REG, 1'b1, 1'b0);
    repeat (2) cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    check("reload_done", 32'(bus.cfg_done),    32'd0);
    check("reload_out",  32'(bus.output_vals), 32'd0);
    rs = {12'($urandom), 32'($urandom)};
    load(rs, 1'b0, 1'b0);
    check("reload_rb", 32'(bus.cfg_rb), 32'(rs[CFG_LEN-1]));
    repeat (3) cyc(1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

`default_nettype wire
